umpire_point_encoder: RTL and testbench

Front-end for `tennis_score_fsm`: converts two raw umpire push-buttons into the clean, single-cycle `p1_point` / `p2_point` pulses the scoring FSM consumes.
- Synchronises, debounces and edge-detects each button.
- Rejects simultaneous presses and enforces one point per press.
- Locks out input briefly after the scorer reports a game win.
- Sits between the board I/O pins and the scoring FSM; its point outputs drive the FSM's point inputs and its game-win inputs are driven by the FSM.

---
 rtl/umpire_point_encoder.sv | 156 +++++++++++++++
 tb/tb_umpire_point_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/umpire_point_encoder.sv
// umpire_point_encoder
//   Turns two raw umpire push-buttons into clean single-cycle point pulses
//   for the scoring FSM. Each button is synchronised, debounced and
//   edge-detected. Simultaneous presses are rejected, and each press can
//   score at most once. Presses are discarded for a short lockout window
//   after the scorer reports a game win.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised cycles needed to accept a level change (>= 1)
//   LOCKOUT_CYCLES   cycles presses are discarded after a game win (>= 1)
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   btn_p1/p2    raw asynchronous buttons, active-high
//   p1/p2_game_win  single-cycle game-won pulses from the scorer
//   p1/p2_point  registered single-cycle point pulses
//   conflict     registered single-cycle pulse, simultaneous press rejected
//   busy         registered, high whenever the controller is not idle

module umpire_point_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_p1,
  input  logic btn_p2,
  input  logic p1_game_win,
  input  logic p2_game_win,
  output logic p1_point,
  output logic p2_point,
  output logic conflict,
  output logic busy
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LK_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0]  LK_LOAD  = LK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT_P1,
    ST_EMIT_P2,
    ST_HOLDOFF,
    ST_LOCKOUT
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] deb;
  logic [1:0] press;

  assign btn_raw = {btn_p2, btn_p1};

  // Per-button synchroniser, debouncer and rising-edge detector.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic             s1_r;
    logic             s2_r;
    logic             deb_r;
    logic             deb_prev_r;
    logic [DEB_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_r       <= 1'b0;
        s2_r       <= 1'b0;
        deb_r      <= 1'b0;
        deb_prev_r <= 1'b0;
        cnt_r      <= '0;
      end else begin
        s1_r       <= btn_raw[g];
        s2_r       <= s1_r;
        deb_prev_r <= deb_r;
        if (s2_r == deb_r) begin
          cnt_r <= '0;
        end else if (cnt_r == DEB_LAST) begin
          deb_r <= s2_r;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + DEB_W'(1);
        end
      end
    end

    assign deb[g]   = deb_r;
    assign press[g] = deb_r & ~deb_prev_r;
  end

  state_t          state;
  state_t          state_d;
  logic [LK_W-1:0] lk_cnt;
  logic [LK_W-1:0] lk_cnt_d;
  logic            p1_point_d;
  logic            p2_point_d;
  logic            conflict_d;
  logic            game_win;

  assign game_win = p1_game_win | p2_game_win;

  // Next-state and next-output logic; a game win overrides everything.
  always_comb begin
    state_d    = state;
    lk_cnt_d   = lk_cnt;
    p1_point_d = 1'b0;
    p2_point_d = 1'b0;
    conflict_d = 1'b0;
    if (game_win) begin
      state_d  = ST_LOCKOUT;
      lk_cnt_d = LK_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press[0] && press[1]) begin
            state_d    = ST_HOLDOFF;
            conflict_d = 1'b1;
          end else if (press[0]) begin
            state_d    = ST_EMIT_P1;
            p1_point_d = 1'b1;
          end else if (press[1]) begin
            state_d    = ST_EMIT_P2;
            p2_point_d = 1'b1;
          end
        end
        ST_EMIT_P1, ST_EMIT_P2: state_d = ST_HOLDOFF;
        // Wait until both buttons are released so a held button cannot score twice.
        ST_HOLDOFF: if (deb == 2'b00) state_d = ST_IDLE;
        ST_LOCKOUT: begin
          if (lk_cnt == '0) state_d = ST_HOLDOFF;
          else              lk_cnt_d = lk_cnt - LK_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lk_cnt   <= '0;
      p1_point <= 1'b0;
      p2_point <= 1'b0;
      conflict <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      lk_cnt   <= lk_cnt_d;
      p1_point <= p1_point_d;
      p2_point <= p2_point_d;
      conflict <= conflict_d;
      busy     <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_umpire_point_encoder.sv
// Bench for umpire_point_encoder: directed button/game-win scenarios, a
// behavioural model compared every cycle, and hand-computed timing checks.

module tb_umpire_point_encoder;

  localparam int D = 4;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_p1 = 1'b0;
  logic btn_p2 = 1'b0;
  logic p1_game_win = 1'b0;
  logic p2_game_win = 1'b0;
  logic p1_point, p2_point, conflict, busy;

  umpire_point_encoder #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_p1(btn_p1),
    .btn_p2(btn_p2),
    .p1_game_win(p1_game_win),
    .p2_game_win(p2_game_win),
    .p1_point(p1_point),
    .p2_point(p2_point),
    .conflict(conflict),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Model: sample histories per button, debounced levels, controller phase.
  localparam int PH_IDLE  = 0;
  localparam int PH_POINT = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_LOCK  = 3;
  logic [63:0] bh [2];
  logic [63:0] sh [2];
  logic [1:0]  m_deb = 2'b00;
  logic [1:0]  m_debp = 2'b00;
  int          phase = PH_IDLE;
  int          lock_left = 0;
  logic        e_p1, e_p2, e_conf, e_busy;

  // Observed statistics for the literal checks.
  int   p1_cnt, p2_cnt, conf_cnt, p1_edge, p2_edge, conf_edge;
  int   busy_rise, busy_fall, busy_rise_cnt;
  logic busy_q = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [1:0] btn_now;
    logic [1:0] press_m;
    logic [1:0] deb_old;
    logic       flip;
    edge_n++;
    btn_now = {btn_p2, btn_p1};
    e_p1   = 1'b0;
    e_p2   = 1'b0;
    e_conf = 1'b0;
    if (!rst_n) begin
      bh[0] = '0; bh[1] = '0; sh[0] = '0; sh[1] = '0;
      m_deb = 2'b00; m_debp = 2'b00;
      phase = PH_IDLE; lock_left = 0;
    end else begin
      press_m = m_deb & ~m_debp;
      deb_old = m_deb;
      if (p1_game_win || p2_game_win) begin
        phase = PH_LOCK;
        lock_left = L;
      end else begin
        case (phase)
          PH_IDLE: begin
            if (press_m == 2'b11) begin e_conf = 1'b1; phase = PH_WAIT; end
            else if (press_m[0]) begin e_p1 = 1'b1; phase = PH_POINT; end
            else if (press_m[1]) begin e_p2 = 1'b1; phase = PH_POINT; end
          end
          PH_POINT: phase = PH_WAIT;
          PH_WAIT:  if (deb_old == 2'b00) phase = PH_IDLE;
          default: begin
            lock_left--;
            if (lock_left == 0) phase = PH_WAIT;
          end
        endcase
      end
      // A level is accepted once the last D synchronised samples all disagree.
      for (int c = 0; c < 2; c++) begin
        sh[c] = {sh[c][62:0], bh[c][1]};
        flip = 1'b1;
        for (int i = 0; i < D; i++)
          if (sh[c][i] == m_deb[c]) flip = 1'b0;
        m_debp[c] = m_deb[c];
        if (flip) m_deb[c] = ~m_deb[c];
        bh[c] = {bh[c][62:0], btn_now[c]};
      end
    end
    e_busy = (phase != PH_IDLE);
    #1;
    n_cmp++;
    if ({p1_point, p2_point, conflict, busy} !== {e_p1, e_p2, e_conf, e_busy}) begin
      n_bad++;
      $display("FAIL outputs @edge %0d: got p1/p2/conf/busy=%b, want %b",
               edge_n, {p1_point, p2_point, conflict, busy}, {e_p1, e_p2, e_conf, e_busy});
    end
    if (p1_point === 1'b1) begin p1_cnt++; p1_edge = edge_n; end
    if (p2_point === 1'b1) begin p2_cnt++; p2_edge = edge_n; end
    if (conflict === 1'b1) begin conf_cnt++; conf_edge = edge_n; end
    if (busy === 1'b1 && !busy_q) begin
      busy_rise_cnt++;
      if (busy_rise < 0) busy_rise = edge_n;
    end
    if (busy === 1'b0 && busy_q) busy_fall = edge_n;
    busy_q = (busy === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_stats();
    p1_cnt = 0; p2_cnt = 0; conf_cnt = 0;
    p1_edge = -1; p2_edge = -1; conf_edge = -1;
    busy_rise = -1; busy_fall = -1; busy_rise_cnt = 0;
  endtask

  initial begin
    int t0;
    clear_stats();
    rst_n = 1'b0;
    cyc(3);
    chk("reset busy", busy, 0);
    chk("reset p1_point", p1_point, 0);
    chk("reset conflict", conflict, 0);
    rst_n = 1'b1;
    cyc(5);

    // Single press on player 1, held for 10 cycles.
    clear_stats();
    btn_p1 = 1'b1; t0 = edge_n + 1;
    cyc(10); btn_p1 = 1'b0; cyc(20);
    chk("single p1 count", p1_cnt, 1);
    chk("single p1 edge", p1_edge - t0, D + 2);
    chk("single p2 count", p2_cnt, 0);
    chk("single busy rise", busy_rise - t0, D + 2);
    chk("single busy fall", busy_fall - t0, 16);

    // Glitch shorter than the debounce window.
    clear_stats();
    btn_p2 = 1'b1; cyc(3); btn_p2 = 1'b0; cyc(15);
    chk("glitch p2 count", p2_cnt, 0);
    chk("glitch busy rises", busy_rise_cnt, 0);

    // Simultaneous press.
    clear_stats();
    btn_p1 = 1'b1; btn_p2 = 1'b1; t0 = edge_n + 1;
    cyc(10); btn_p1 = 1'b0; btn_p2 = 1'b0; cyc(20);
    chk("simul conflict count", conf_cnt, 1);
    chk("simul conflict edge", conf_edge - t0, 6);
    chk("simul point count", p1_cnt + p2_cnt, 0);
    chk("simul busy fall", busy_fall - t0, 16);

    // Overlapping press: p2 pressed while p1 held.
    clear_stats();
    btn_p1 = 1'b1; t0 = edge_n + 1;
    cyc(2); btn_p2 = 1'b1;
    cyc(10); btn_p1 = 1'b0; btn_p2 = 1'b0; cyc(20);
    chk("overlap p1 count", p1_cnt, 1);
    chk("overlap p2 count", p2_cnt, 0);
    chk("overlap p1 edge", p1_edge - t0, 6);
    chk("overlap busy fall", busy_fall - t0, 18);

    // Bare game win: LOCKOUT_CYCLES of lockout plus one holdoff cycle.
    clear_stats();
    p1_game_win = 1'b1; t0 = edge_n + 1;
    cyc(1); p1_game_win = 1'b0; cyc(15);
    chk("lockout busy rise", busy_rise - t0, 0);
    chk("lockout busy fall", busy_fall - t0, L + 1);

    // Press during lockout, held past expiry: never scores.
    clear_stats();
    p2_game_win = 1'b1; t0 = edge_n + 1;
    cyc(1); p2_game_win = 1'b0;
    cyc(1); btn_p2 = 1'b1;
    cyc(20); btn_p2 = 1'b0; cyc(15);
    chk("lockout held p2 count", p2_cnt, 0);
    chk("lockout held busy fall", busy_fall - t0, 28);

    // Fresh press after lockout scores once.
    clear_stats();
    btn_p2 = 1'b1; t0 = edge_n + 1;
    cyc(10); btn_p2 = 1'b0; cyc(20);
    chk("fresh p2 count", p2_cnt, 1);
    chk("fresh p2 edge", p2_edge - t0, 6);

    // Game win on the same edge the press would be accepted.
    clear_stats();
    btn_p1 = 1'b1; t0 = edge_n + 1;
    cyc(6); p1_game_win = 1'b1;
    cyc(1); p1_game_win = 1'b0;
    cyc(10); btn_p1 = 1'b0; cyc(20);
    chk("win priority p1 count", p1_cnt, 0);
    chk("win priority busy rise", busy_rise - t0, 6);
    chk("win priority busy fall", busy_fall - t0, 23);

    // Reset during EMIT_P1 with the button released before reset ends.
    clear_stats();
    btn_p1 = 1'b1; t0 = edge_n + 1;
    cyc(7); rst_n = 1'b0; btn_p1 = 1'b0;
    cyc(2); rst_n = 1'b1; cyc(20);
    chk("reset mid p1 count", p1_cnt, 1);
    chk("reset mid busy fall", busy_fall - t0, 7);

    // Button held through reset release counts as a new press.
    clear_stats();
    btn_p1 = 1'b1;
    cyc(10); rst_n = 1'b0;
    cyc(2); rst_n = 1'b1; t0 = edge_n + 1;
    cyc(15); btn_p1 = 1'b0; cyc(20);
    chk("held reset p1 count", p1_cnt, 2);
    chk("held reset p1 edge", p1_edge - t0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
